sprite_motion_controller: RTL and testbench
===========================================

# sprite_motion_controller

Computes the on-screen position of the 64×64 sprite once per frame and drives the `posx`/`posy` inputs of the sprite printer stage directly upstream of it. It supports two modes: an autonomous bounce mode and a manual pushbutton mode. Positions change only during vertical sync, so the printer never sees a position change mid-frame.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line.
- `V_ACTIVE`, default 480: visible lines per frame.
- `SPRITE_W`, default 64: sprite width in pixels.
- `SPRITE_H`, default 64: sprite height in pixels.
- `STEP`, default 2: pixels moved per frame, per axis. Must satisfy 1 ≤ `STEP` < `SPRITE_W`.
- `X0`, default 288: reset x position.
- `Y0`, default 208: reset y position.

Ports:
- `clk`  in  1  pixel clock, the same clock as the VGA controller. One clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `vsync`  in  1  VGA vertical sync, active low. Treated as asynchronous and synchronized internally.
- `enable`  in  1  when 0, position updates are frozen (state still advances).
- `mode`  in  1  0 = auto bounce, 1 = manual. Sampled at the frame tick.
- `btn_left`, `btn_right`, `btn_up`, `btn_down`  in  1 each  pushbuttons, active high, asynchronous.
- `posx`  out  10  sprite top-left x, registered.
- `posy`  out  10  sprite top-left y, registered.
- `frame_tick`  out  1  one-cycle pulse marking the start of vsync.
- `dirx`, `diry`  out  1 each  current bounce direction: 0 = increasing, 1 = decreasing.

## Operation
Synchronization and frame tick:
- `vsync` and all four buttons each pass through a 2-flop synchronizer.
- A falling edge on the synchronized `vsync` produces `frame_tick`.

State machine, states IDLE → UPD_X → UPD_Y → IDLE:
- IDLE: wait for `frame_tick`. On the tick, latch `mode` and the four synchronized buttons into `mode_q` and `btn_q`, then go to UPD_X.
- UPD_X: compute and register the new `posx`/`dirx`. Go to UPD_Y.
- UPD_Y: compute and register the new `posy`/`diry`. Go to IDLE.
- A `frame_tick` that arrives while the FSM is in UPD_X or UPD_Y is ignored.

Limits and arithmetic:
- Per-axis upper limits: XMAX = `H_ACTIVE`−`SPRITE_W` (576); YMAX = `V_ACTIVE`−`SPRITE_H` (416).
- All sums are formed 11 bits wide, so nothing overflows before the compare.
- Subtraction checks `pos < STEP` before subtracting, so nothing underflows.

Auto mode (`mode_q` = 0), per axis:
- dir = 0: if pos+`STEP` ≥ MAX, set pos = MAX and dir = 1. Otherwise pos += `STEP`.
- dir = 1: if pos ≤ `STEP`, set pos = 0 and dir = 0. Otherwise pos −= `STEP`.
- Exactly reaching a limit clamps to the limit and flips the direction in the same update.

Manual mode (`mode_q` = 1):
- Left/up subtract `STEP`, clamping at 0. Right/down add `STEP`, clamping at MAX.
- Left and right both held: no x motion. Up and down both held: no y motion.
- `dirx`/`diry` hold their values in manual mode.

Enable:
- When `enable` = 0 in UPD_X/UPD_Y, the position and direction registers hold. The FSM still cycles.

Mode change:
- A change of `mode` takes effect at the next frame tick.
- Positions carry over unchanged.

Reset values (asynchronous, on `rst` = 0):
- `posx` = `X0`, `posy` = `Y0`.
- `dirx` = `diry` = 0.
- `frame_tick` = 0.
- State = IDLE.
- Synchronizer flops = 1 for `vsync`, 0 for buttons.
- A reset asserted mid-update abandons the update. After release, nothing moves until the next frame tick.

## Timing
- `vsync` falling edge to `frame_tick` high: 3 clk edges (2 synchronizer stages plus the edge-detect register). The pulse lasts exactly 1 cycle.
- `posx` updates on the first clk edge after `frame_tick`. `posy` updates one edge later.
- Both positions are stable no later than 5 cycles after the `vsync` fall, well inside vertical blanking.
- Outputs are constant from UPD_Y until the next frame tick.
- No output is combinational from any input.

## Test plan
- Reset release, then one `vsync` pulse, auto mode → `posx` 288→290 and `posy` 208→210. `frame_tick` is high for 1 cycle, 3 edges after the `vsync` fall. `posx` changes 1 cycle after the tick, `posy` 1 cycle after `posx`.
- Auto mode, x forced to 575 with `dirx` = 0 → next frame `posx` = 576 and `dirx` = 1. The following frame `posx` = 574. Likewise y at 1 with `diry` = 1 → 0, `diry` = 0.
- Manual mode, `btn_right` held for 300 frames from x = 288 → `posx` saturates at 576 after 144 frames and stays there. Left and right held together → `posx` unchanged.
- `enable` = 0 across 10 frames → `posx`/`posy` unchanged and `frame_tick` still pulses every frame. Re-enable → motion resumes from the held values.
- `rst` asserted during UPD_X → all outputs return immediately (asynchronously) to their reset values. After release, no movement occurs until the next `vsync` falling edge.
- `mode` toggled mid-frame → the update for that frame follows the old mode. The next frame follows the new mode with the position continuing from its current value.

Source files
------------

// File: rtl/sprite_motion_controller.sv
// Per-frame position generator for a sprite. It bounces the sprite off the screen edges in auto mode,
// or steps it with pushbuttons in manual mode. All position updates happen right after the vsync falling edge.
module sprite_motion_controller #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPRITE_W = 64,
    parameter int SPRITE_H = 64,
    parameter int STEP     = 2,
    parameter int X0       = 288,
    parameter int Y0       = 208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       enable,
    input  logic       mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic       frame_tick,
    output logic       dirx,
    output logic       diry
);

    localparam logic [10:0] XMAX   = 11'(H_ACTIVE - SPRITE_W);
    localparam logic [10:0] YMAX   = 11'(V_ACTIVE - SPRITE_H);
    localparam logic [10:0] STEP_W = 11'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_UPD_X, S_UPD_Y} state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    // Next position/direction for one axis. All arithmetic is 11 bits wide,
    // and the subtraction is guarded, so neither overflow nor underflow can happen.
    function automatic axis_t step_axis(input logic [9:0] pos, input logic dir,
                                        input logic manual, input logic dec,
                                        input logic inc, input logic [10:0] lim);
        logic [10:0] w_pos;
        logic [10:0] w_sum;
        logic [10:0] w_diff;
        axis_t       res;
        w_pos  = {1'b0, pos};
        w_sum  = w_pos + STEP_W;
        w_diff = w_pos - STEP_W;
        res    = '{pos: pos, dir: dir};
        if (!manual) begin
            if (!dir) begin
                if (w_sum >= lim) res = '{pos: lim[9:0], dir: 1'b1};
                else              res.pos = w_sum[9:0];
            end else begin
                if (w_pos <= STEP_W) res = '{pos: 10'd0, dir: 1'b0};
                else                 res.pos = w_diff[9:0];
            end
        end else if (dec && !inc) begin
            res.pos = (w_pos < STEP_W) ? 10'd0 : w_diff[9:0];
        end else if (inc && !dec) begin
            res.pos = (w_sum >= lim) ? lim[9:0] : w_sum[9:0];
        end
        return res;
    endfunction

    logic       r_vs_meta, r_vs_sync, r_vs_d;
    logic [3:0] r_btn_meta, r_btn_sync;
    logic       w_tick;

    // NOTE: every flop uses non-blocking assignment so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vs_meta  <= 1'b1;
            r_vs_sync  <= 1'b1;
            r_vs_d     <= 1'b1;
            r_btn_meta <= 4'b0;
            r_btn_sync <= 4'b0;
            frame_tick <= 1'b0;
        end else begin
            r_vs_meta  <= vsync;
            r_vs_sync  <= r_vs_meta;
            r_vs_d     <= r_vs_sync;
            r_btn_meta <= {btn_left, btn_right, btn_up, btn_down};
            r_btn_sync <= r_btn_meta;
            frame_tick <= w_tick;
        end
    end

    // The FSM reacts to the unregistered edge so that posx can move on the
    // very edge after frame_tick rises, the same edge that lowers frame_tick.
    assign w_tick = r_vs_d & ~r_vs_sync;

    state_t     r_state;
    logic       r_mode_q;
    logic [3:0] r_btn_q;
    axis_t      w_next_x, w_next_y;

    assign w_next_x = step_axis(posx, dirx, r_mode_q, r_btn_q[3], r_btn_q[2], XMAX);
    assign w_next_y = step_axis(posy, diry, r_mode_q, r_btn_q[1], r_btn_q[0], YMAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_mode_q <= 1'b0;
            r_btn_q  <= 4'b0;
            posx     <= 10'(X0);
            posy     <= 10'(Y0);
            dirx     <= 1'b0;
            diry     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_mode_q <= mode;
                        r_btn_q  <= r_btn_sync;
                        r_state  <= S_UPD_X;
                    end
                end
                S_UPD_X: begin
                    if (enable) begin
                        posx <= w_next_x.pos;
                        dirx <= w_next_x.dir;
                    end
                    r_state <= S_UPD_Y;
                end
                S_UPD_Y: begin
                    if (enable) begin
                        posy <= w_next_y.pos;
                        diry <= w_next_y.dir;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_controller.sv
// Directed bench for sprite_motion_controller using the default 640x480 parameters.
// Every expected value below is worked out by hand from the movement rules.
module tb_sprite_motion_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       enable;
    logic       mode;
    logic       btn_left, btn_right, btn_up, btn_down;
    logic [9:0] posx, posy;
    logic       frame_tick;
    logic       dirx, diry;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;

    sprite_motion_controller dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .enable     (enable),
        .mode       (mode),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .posx       (posx),
        .posy       (posy),
        .frame_tick (frame_tick),
        .dirx       (dirx),
        .diry       (diry)
    );

    always #5 clk = ~clk;

    // One clock: advance to the falling edge, then count any tick seen there.
    task automatic cycle();
        @(negedge clk);
        if (frame_tick === 1'b1) ticks++;
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            vsync = 1'b0;
            repeat (4) cycle();
            vsync = 1'b1;
            repeat (8) cycle();
        end
    endtask

    task automatic expect_pos(input string name, input int ex, input int ey,
                              input logic edx, input logic edy);
        checks++;
        if (posx !== 10'(ex) || posy !== 10'(ey) || dirx !== edx || diry !== edy) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d dx=%0b dy=%0b, expected x=%0d y=%0d dx=%0b dy=%0b",
                     name, posx, posy, dirx, diry, ex, ey, edx, edy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; vsync = 1'b1; enable = 1'b1; mode = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        repeat (3) cycle();
        expect_pos("reset_pos", 288, 208, 1'b0, 1'b0);
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: got %0b expected 0", frame_tick);
        end
        rst = 1'b1;
        repeat (4) cycle();
    endtask

    task automatic test_first_frame();
        logic [4:0] tick_seq;
        vsync = 1'b0;
        for (int e = 0; e < 5; e++) begin
            cycle();
            tick_seq[e] = frame_tick;
            if (e == 2) expect_pos("pre_update", 288, 208, 1'b0, 1'b0);
            if (e == 3) expect_pos("x_after_tick", 290, 208, 1'b0, 1'b0);
            if (e == 4) expect_pos("y_one_later", 290, 210, 1'b0, 1'b0);
        end
        checks++;
        if (tick_seq !== 5'b00100) begin
            errors++;
            $display("FAIL tick_timing: got %b expected 00100 (edge5..edge1)", tick_seq);
        end
        vsync = 1'b1;
        repeat (8) cycle();
    endtask

    task automatic test_manual();
        mode = 1'b1; btn_right = 1'b1;
        run_frames(150);
        expect_pos("manual_right_sat", 576, 210, 1'b0, 1'b0);
        btn_left = 1'b1;
        run_frames(5);
        expect_pos("manual_left_right", 576, 210, 1'b0, 1'b0);
        btn_right = 1'b0;
        run_frames(1);
        expect_pos("manual_left", 574, 210, 1'b0, 1'b0);
        btn_left = 1'b0;
    endtask

    task automatic test_bounce();
        mode = 1'b0;
        run_frames(1);
        expect_pos("x_hit_max", 576, 212, 1'b1, 1'b0);
        run_frames(1);
        expect_pos("x_leave_max", 574, 214, 1'b1, 1'b0);
        run_frames(101);
        expect_pos("y_hit_max", 372, 416, 1'b1, 1'b1);
        mode = 1'b1; btn_up = 1'b1;
        run_frames(207);
        expect_pos("manual_up_dir_hold", 372, 2, 1'b1, 1'b1);
        btn_up = 1'b0; mode = 1'b0;
        run_frames(1);
        expect_pos("y_hit_zero", 370, 0, 1'b1, 1'b0);
        run_frames(1);
        expect_pos("y_leave_zero", 368, 2, 1'b1, 1'b0);
    endtask

    task automatic test_enable();
        enable = 1'b0;
        ticks  = 0;
        run_frames(10);
        expect_pos("disabled_hold", 368, 2, 1'b1, 1'b0);
        checks++;
        if (ticks != 10) begin
            errors++;
            $display("FAIL disabled_ticks: got %0d expected 10", ticks);
        end
        enable = 1'b1;
        run_frames(1);
        expect_pos("reenable", 366, 4, 1'b1, 1'b0);
    endtask

    task automatic test_mode_toggle();
        btn_right = 1'b1;
        vsync = 1'b0;
        repeat (3) cycle();
        mode = 1'b1;
        repeat (1) cycle();
        vsync = 1'b1;
        repeat (10) cycle();
        expect_pos("toggle_old_mode", 364, 6, 1'b1, 1'b0);
        run_frames(1);
        expect_pos("toggle_new_mode", 366, 6, 1'b1, 1'b0);
        btn_right = 1'b0; mode = 1'b0;
    endtask

    task automatic test_reset_mid_update();
        vsync = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        #1;
        expect_pos("async_reset", 288, 208, 1'b0, 1'b0);
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_tick: got %0b expected 0", frame_tick);
        end
        repeat (2) cycle();
        vsync = 1'b1;
        cycle();
        rst = 1'b1;
        ticks = 0;
        repeat (20) cycle();
        expect_pos("post_reset_idle", 288, 208, 1'b0, 1'b0);
        checks++;
        if (ticks != 0) begin
            errors++;
            $display("FAIL post_reset_ticks: got %0d expected 0", ticks);
        end
        run_frames(1);
        expect_pos("post_reset_frame", 290, 210, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_manual();
        test_bounce();
        test_enable();
        test_mode_toggle();
        test_reset_mid_update();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
